// File: rtl/pad_bidir_ctrl.sv
// pad_bidir_ctrl: bidirectional pad direction control with turnaround, tx capture and debounced receive
module pad_bidir_ctrl #(
  parameter int N = 8,
  parameter int TA_CYC = 2,
  parameter int DB_CYC = 4
) (
  input  logic         axis_clk,
  input  logic         axis_rst_n,
  input  logic         dir_req,
  input  logic         pull_en,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [N-1:0] rx_data,
  output logic         rx_chg,
  output logic         cur_dir,
  output logic         busy,
  output logic [N-1:0] pad_i,
  output logic [N-1:0] pad_oen,
  output logic [N-1:0] pad_ren,
  input  logic [N-1:0] pad_c
);
  typedef enum logic [1:0] {IN, TA_OUT, OUT, TA_IN} state_t;
  localparam logic [3:0] TA_LAST = 4'(TA_CYC - 1);
  localparam logic [7:0] DB_LAST = 8'(DB_CYC - 1);
  state_t st, nxt;
  logic [3:0] tc, tc_n;
  logic [7:0] cnt;
  logic [N-1:0] s1, s2, s_last;
  assign tx_ready = (st == OUT) && dir_req;
  assign cur_dir = st == OUT;
  assign busy = (st == TA_OUT) || (st == TA_IN);
  // next state and turnaround count; an aborted TA_OUT falls straight back to IN
  always_comb begin
    nxt = st;
    tc_n = tc;
    case (st)
      IN: begin
        nxt = dir_req ? TA_OUT : IN;
        tc_n = '0;
      end
      TA_OUT: begin
        nxt = !dir_req ? IN : (tc == TA_LAST) ? OUT : TA_OUT;
        tc_n = (!dir_req || tc == TA_LAST) ? '0 : tc + 4'd1;
      end
      OUT: begin
        nxt = dir_req ? OUT : TA_IN;
        tc_n = '0;
      end
      default: begin
        nxt = (tc == TA_LAST) ? IN : TA_IN;
        tc_n = (tc == TA_LAST) ? '0 : tc + 4'd1;
      end
    endcase
  end
  // state, pad enables and tx capture; enables are registered from the next state so they track st
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      st <= IN;
      tc <= '0;
      pad_oen <= '1;
      pad_ren <= '1;
      pad_i <= '0;
    end else begin
      st <= nxt;
      tc <= tc_n;
      pad_oen <= (nxt == OUT) ? '0 : '1;
      pad_ren <= (nxt == IN && pull_en) ? '0 : '1;
      pad_i <= (tx_valid && tx_ready) ? tx_data : pad_i;
    end
  end
  // synchronize pad_c always; debounce only while receiving
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s_last <= '0;
      cnt <= '0;
      rx_data <= '0;
      rx_chg <= 1'b0;
    end else begin
      s1 <= pad_c;
      s2 <= s1;
      s_last <= s2;
      rx_chg <= 1'b0;
      if (st != IN || s2 != s_last || s2 == rx_data) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt <= '0;
        rx_data <= s2;
        rx_chg <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_pad_bidir_ctrl.sv
// tb_pad_bidir_ctrl: directed self-checking bench for pad_bidir_ctrl
module tb_pad_bidir_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dir_req = 1'b0, pull_en = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = '0, pad_c = '0;
  logic tx_ready, rx_chg, cur_dir, busy;
  logic [7:0] rx_data, pad_i, pad_oen, pad_ren;
  int n_cmp = 0, n_bad = 0;
  pad_bidir_ctrl #(.N(8), .TA_CYC(2), .DB_CYC(4)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .dir_req(dir_req), .pull_en(pull_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_chg(rx_chg), .cur_dir(cur_dir), .busy(busy), .pad_i(pad_i),
    .pad_oen(pad_oen), .pad_ren(pad_ren), .pad_c(pad_c)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_oen"}, 32'(pad_oen), 32'hFF);
    chk({tag, "_ren"}, 32'(pad_ren), 32'hFF);
    chk({tag, "_pad_i"}, 32'(pad_i), 32'h0);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    chk({tag, "_rx_chg"}, 32'(rx_chg), 32'h0);
    chk({tag, "_cur_dir"}, 32'(cur_dir), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'h0);
  endtask
  initial begin
    tick();
    tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");
    pull_en = 1'b1;
    tick();
    chk("pull_in", 32'(pad_ren), 32'h00);
    pad_c = 8'h3C;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("db_data_e%0d", i), 32'(rx_data), (i >= 7) ? 32'h3C : 32'h0);
      chk($sformatf("db_chg_e%0d", i), 32'(rx_chg), (i == 7) ? 32'h1 : 32'h0);
    end
    tick();
    chk("db_chg_drop", 32'(rx_chg), 32'h0);
    pad_c = 8'hFF;
    tick();
    tick();
    pad_c = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("glitch_data_%0d", i), 32'(rx_data), 32'h3C);
      chk($sformatf("glitch_chg_%0d", i), 32'(rx_chg), 32'h0);
    end
    dir_req = 1'b1;
    tick();
    chk("ta1_busy", 32'(busy), 32'h1);
    chk("ta1_oen", 32'(pad_oen), 32'hFF);
    chk("ta1_ren", 32'(pad_ren), 32'hFF);
    chk("ta1_cur_dir", 32'(cur_dir), 32'h0);
    chk("ta1_tx_ready", 32'(tx_ready), 32'h0);
    tick();
    chk("ta2_busy", 32'(busy), 32'h1);
    chk("ta2_oen", 32'(pad_oen), 32'hFF);
    tick();
    chk("out_oen", 32'(pad_oen), 32'h00);
    chk("out_cur_dir", 32'(cur_dir), 32'h1);
    chk("out_tx_ready", 32'(tx_ready), 32'h1);
    chk("out_busy", 32'(busy), 32'h0);
    chk("out_ren", 32'(pad_ren), 32'hFF);
    pad_c = 8'h81;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    tick();
    chk("tx_load", 32'(pad_i), 32'hA5);
    tx_data = 8'h5A;
    tx_valid = 1'b0;
    tick();
    chk("tx_hold", 32'(pad_i), 32'hA5);
    dir_req = 1'b0;
    #1;
    chk("tx_ready_drop", 32'(tx_ready), 32'h0);
    tick();
    chk("tain_oen", 32'(pad_oen), 32'hFF);
    chk("tain_busy", 32'(busy), 32'h1);
    chk("tain_cur_dir", 32'(cur_dir), 32'h0);
    chk("tain_pad_i", 32'(pad_i), 32'hA5);
    dir_req = 1'b1;
    tick();
    chk("tain2_busy", 32'(busy), 32'h1);
    chk("tain2_oen", 32'(pad_oen), 32'hFF);
    chk("tain2_rx_hold", 32'(rx_data), 32'h3C);
    dir_req = 1'b0;
    tick();
    chk("in_busy", 32'(busy), 32'h0);
    chk("in_cur_dir", 32'(cur_dir), 32'h0);
    chk("in_ren", 32'(pad_ren), 32'h00);
    chk("in_pad_i", 32'(pad_i), 32'hA5);
    tick();
    chk("in_stay_busy", 32'(busy), 32'h0);
    pad_c = 8'h3C;
    dir_req = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'h1);
    chk("abort_oen1", 32'(pad_oen), 32'hFF);
    chk("abort_ready1", 32'(tx_ready), 32'h0);
    dir_req = 1'b0;
    #1;
    chk("abort_ready2", 32'(tx_ready), 32'h0);
    tick();
    chk("abort_in_busy", 32'(busy), 32'h0);
    chk("abort_oen2", 32'(pad_oen), 32'hFF);
    chk("abort_cur_dir", 32'(cur_dir), 32'h0);
    tick();
    chk("abort_oen3", 32'(pad_oen), 32'hFF);
    chk("abort_ready3", 32'(tx_ready), 32'h0);
    dir_req = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_pre_oen", 32'(pad_oen), 32'h00);
    tx_data = 8'h66;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("rst_pre_pad_i", 32'(pad_i), 32'h66);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    dir_req = 1'b0;
    pull_en = 1'b0;
    pad_c = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("rst_release");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pad_bidir_ctrl.md
PAD_BIDIR_CTRL -- requirements
Module: pad_bidir_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: number of bidirectional pads driven.
REQ-002 SHALL have parameter TA_CYC, default 2: bus-turnaround cycles; legal range 1..15.
REQ-003 SHALL have parameter DB_CYC, default 4: input debounce stability cycles; legal range 1..255.
REQ-004 SHALL have port axis_clk, input, 1: sole clock; all flops rising-edge.
REQ-005 SHALL have port axis_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port dir_req, input, 1: requested direction, 1 = drive pads, 0 = receive.
REQ-007 SHALL have port pull_en, input, 1: request pad pull in receive mode.
REQ-008 SHALL have port tx_data, input, N: data to drive.
REQ-009 SHALL have port tx_valid, input, 1: tx_data valid.
REQ-010 SHALL have port tx_ready, output, 1: block accepts tx_data.
REQ-011 SHALL have port rx_data, output, N: synchronized, debounced pad value.
REQ-012 SHALL have port rx_chg, output, 1: one-cycle pulse on each rx_data update.
REQ-013 SHALL have port cur_dir, output, 1: 1 only while pads are actively driven.
REQ-014 SHALL have port busy, output, 1: turnaround in progress.
REQ-015 SHALL have ports pad_i (output, N: pad drive data), pad_oen (output, N: active-low output enable), pad_ren (output, N: active-low pull enable), and pad_c (input, N: pad receive value).

Function
REQ-016 SHALL implement FSM states IN, TA_OUT, OUT, TA_IN with a turnaround counter.
REQ-017 IN: dir_req=1 at an edge SHALL enter TA_OUT.
REQ-018 TA_OUT: after TA_CYC cycles SHALL enter OUT; if dir_req=0 at any TA_OUT edge, SHALL return to IN immediately.
REQ-019 OUT: dir_req=0 at an edge SHALL enter TA_IN.
REQ-020 TA_IN: SHALL always complete TA_CYC cycles, then enter IN, ignoring dir_req.
REQ-021 pad_oen SHALL be registered: all-zeros exactly while state=OUT, all-ones otherwise.
REQ-022 cur_dir SHALL equal (state==OUT); busy SHALL equal (state==TA_OUT or TA_IN).
REQ-023 tx_ready SHALL equal (state==OUT and dir_req=1), decoded combinationally from the state register.
REQ-024 On tx_valid and tx_ready at an edge, pad_i SHALL load tx_data; otherwise pad_i SHALL hold.
REQ-025 pad_ren SHALL be registered: all-zeros when state=IN and pull_en=1, all-ones otherwise.
REQ-026 pad_c SHALL pass through a 2-flop synchronizer (s1, s2) every cycle in all states; s_last SHALL register s2.
REQ-027 Debounce, evaluated only in state IN:
  - cnt cleared when s2!=s_last or s2==rx_data
  - else cnt increments
  - at cnt==DB_CYC-1 with s2!=rx_data: rx_data<=s2, cnt<=0, rx_chg=1 next cycle
REQ-028 Outside IN, cnt SHALL be held at 0 and rx_data SHALL hold.
REQ-029 Latency: a pad_c change stable from before edge 1 SHALL appear on rx_data after edge DB_CYC+3.
REQ-030 Simultaneous tx handshake and dir_req falling SHALL NOT occur, because tx_ready already reads 0 in that cycle.

Reset
REQ-031 While axis_rst_n=0, all of the following SHALL hold, with pad_oen releasing asynchronously:
  - state=IN; pad_oen all-ones; pad_ren all-ones; pad_i=0
  - rx_data=0; rx_chg=0
  - s1, s2, s_last, cnt, turnaround counter = 0
  - cur_dir=0; busy=0; tx_ready=0
REQ-032 Reset asserted in OUT SHALL release the pads (pad_oen all-ones) without a clock edge; after deassertion the block SHALL behave as from power-up.

Verification
REQ-033 Direction turnaround (TA_CYC=2): dir_req 1 sampled at edge 1 -> busy=1 after edge 1; pad_oen=0x00, cur_dir=1, tx_ready=1 after edge 3.
REQ-034 Transmit: in OUT, tx_data=0xA5 with tx_valid for one cycle -> pad_i=0xA5 after that edge and held; dir_req falls -> pad_oen=0xFF after next edge, pad_i stays 0xA5, IN reached TA_CYC cycles later.
REQ-035 Aborted turnaround: dir_req pulses high one cycle then low -> TA_OUT entered then IN; pad_oen never leaves 0xFF; tx_ready never 1.
REQ-036 Debounce (DB_CYC=4), two cases:
  - pad_c 0x00->0x3C stable -> rx_data=0x3C after edge 7, rx_chg one cycle
  - a 2-cycle 0xFF glitch -> no rx_data change, no rx_chg
REQ-037 Pull control: pull_en=1 in IN -> pad_ren=0x00; dir_req=1 -> pad_ren=0xFF from TA_OUT entry onward.
REQ-038 Reset mid-OUT: axis_rst_n low between edges -> pad_oen=0xFF before next edge; all outputs at REQ-031 values.
